// File: rtl/mul_serial.sv
// Serial shift-add unsigned multiplier: one partial product per clock,
// DATA_W iterations per operation, full 2*DATA_W-bit exact product.
module mul_serial #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     op_a_i,
    input  logic [DATA_W-1:0]     op_b_i,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product_o
);

    localparam int unsigned P_W   = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   a_d;
    logic [P_W-1:0]      p_q;
    logic [P_W-1:0]      p_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                busy_d;
    logic                done_d;
    logic                accept_c;
    logic [DATA_W:0]     sum_c;

    // Partial sum: upper half of P plus the multiplicand when the current multiplier bit is set
    always_comb begin
        sum_c = {1'b0, p_q[P_W-1:DATA_W]} + (p_q[0] ? {1'b0, a_q} : '0);
    end

    // Next-state, datapath update and registered-output decode
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                end
            end
            S_RUN: begin
                // Start is ignored here; only the shift-add iteration advances
                p_d   = {sum_c, p_q[DATA_W-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Back-to-back: a start here reloads and reruns immediately
                if (start) begin
                    accept_c = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept_c) begin
            a_d     = op_a_i;
            p_d     = {{DATA_W{1'b0}}, op_b_i};
            cnt_d   = '0;
            state_d = S_RUN;
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Product register is exposed directly; it holds until the next accept
    assign product_o = p_q;

endmodule

// File: tb/tb_mul_serial.sv
// Self-checking bench for mul_serial at DATA_W=8 (directed + random) and
// DATA_W=16 (random), with expected products queued at each accept.
`timescale 1ns/1ps
module tb_mul_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DATA_W = 8 instance
    logic        rst_n8, start8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    // DATA_W = 16 instance
    logic        rst_n16, start16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] product16;

    mul_serial #(.DATA_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n8), .start(start8),
        .op_a_i(a8), .op_b_i(b8),
        .busy(busy8), .done(done8), .product_o(product8)
    );

    mul_serial #(.DATA_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n16), .start(start16),
        .op_a_i(a16), .op_b_i(b16),
        .busy(busy16), .done(done16), .product_o(product16)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] q8[$];
    logic [31:0] q16[$];
    bit          fin16 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp_v, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // One operation with cycle-exact busy/done checks; optional re-pulse of start mid-RUN
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input bit repulse);
        logic [31:0] exp_v;
        exp_v  = 32'(a) * 32'(b);
        a8     = a;
        b8     = b;
        start8 = 1'b1;
        q8.push_back(exp_v);
        @(negedge clk);
        check("idle_busy8", 32'(busy8), 0);
        cyc();
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        for (int k = 1; k <= 9; k++) begin
            if (repulse && k == 4) begin
                start8 = 1'b1;
                a8     = 8'hAA;
                b8     = 8'h55;
            end
            if (repulse && k == 5) start8 = 1'b0;
            @(negedge clk);
            check("busy8", 32'(busy8), 32'(k <= 8));
            check("done8", 32'(done8), 32'(k == 9));
            cyc();
        end
        @(negedge clk);
        check("hold8", 32'(product8), exp_v);
        check("done_after8", 32'(done8), 0);
        cyc();
    endtask

    // Scoreboard for the 8-bit instance
    always @(negedge clk) begin
        if (done8) begin
            check("done_busy8", 32'(busy8), 0);
            if (q8.size() == 0) check("spurious_done8", 32'(done8), 0);
            else                check("product8", 32'(product8), q8.pop_front());
        end
    end

    // Scoreboard for the 16-bit instance
    always @(negedge clk) begin
        if (done16) begin
            check("done_busy16", 32'(busy16), 0);
            if (q16.size() == 0) check("spurious_done16", 32'(done16), 0);
            else                 check("product16", product16, q16.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed and random stimulus for DATA_W = 8
    initial begin
        bit seen;
        rst_n8 = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) cyc();
        @(negedge clk);
        check("rst_busy8", 32'(busy8), 0);
        check("rst_done8", 32'(done8), 0);
        check("rst_prod8", 32'(product8), 0);
        cyc();
        rst_n8 = 1'b1;
        run_op8(8'd3, 8'd5, 1'b0);
        run_op8(8'd255, 8'd255, 1'b0);
        run_op8(8'd0, 8'd200, 1'b0);
        run_op8(8'd11, 8'd13, 1'b1);

        // start held high across two operations
        a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
        q8.push_back(32'd63);
        cyc();
        a8 = 8'd12; b8 = 8'd12;
        repeat (8) cyc();
        q8.push_back(32'd144);
        @(negedge clk);
        check("b2b_done9", 32'(done8), 1);
        cyc();
        @(negedge clk);
        check("b2b_busy10", 32'(busy8), 1);
        repeat (8) cyc();
        start8 = 1'b0;
        @(negedge clk);
        check("b2b_done18", 32'(done8), 1);
        cyc();
        @(negedge clk);
        check("b2b_idle_done", 32'(done8), 0);
        check("b2b_idle_busy", 32'(busy8), 0);
        cyc();

        // reset in cycle 5 of RUN, with start asserted alongside it
        a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
        q8.push_back(32'd20000);
        cyc();
        start8 = 1'b0;
        repeat (4) cyc();
        rst_n8 = 1'b0; start8 = 1'b1;
        q8.delete();
        cyc();
        @(negedge clk);
        check("abort_busy", 32'(busy8), 0);
        check("abort_done", 32'(done8), 0);
        check("abort_prod", 32'(product8), 0);
        cyc();
        rst_n8 = 1'b1;
        run_op8(8'd6, 8'd7, 1'b0);

        // random regression
        for (int i = 0; i < 2000; i++) begin
            a8 = pick8(); b8 = pick8(); start8 = 1'b1;
            q8.push_back(32'(a8) * 32'(b8));
            cyc();
            start8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom);
            seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                @(negedge clk);
                if (done8) seen = 1'b1;
            end
            if (!seen) begin
                check("timeout8", 0, 1);
                q8.delete();
            end
            cyc();
            repeat ($urandom_range(0, 1)) cyc();
        end

        while (!fin16) cyc();
        repeat (3) cyc();
        check("pending8", 32'(q8.size()), 0);
        check("pending16", 32'(q16.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Random stimulus for DATA_W = 16
    initial begin
        bit seen;
        rst_n16 = 1'b0; start16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) cyc();
        rst_n16 = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            a16 = pick16(); b16 = pick16(); start16 = 1'b1;
            q16.push_back(32'(a16) * 32'(b16));
            cyc();
            start16 = 1'b0;
            a16 = 16'($urandom); b16 = 16'($urandom);
            seen = 1'b0;
            for (int k = 0; k < 60 && !seen; k++) begin
                @(negedge clk);
                if (done16) seen = 1'b1;
            end
            if (!seen) begin
                check("timeout16", 0, 1);
                q16.delete();
            end
            cyc();
            repeat ($urandom_range(0, 1)) cyc();
        end
        fin16 = 1'b1;
    end

endmodule
